// File: rtl/render_scheduler_if.sv
// Rectangle draw-engine bus: render_scheduler drives the descriptor and handshake (master),
// the draw engine answers with draw_done (slave).
interface render_scheduler_if;
    logic [7:0] draw_x;
    logic [6:0] draw_y;
    logic [4:0] draw_w;
    logic [4:0] draw_h;
    logic [2:0] draw_c;
    logic       draw_load;
    logic       draw_en;
    logic       draw_done;

    modport master (
        output draw_x, draw_y, draw_w, draw_h, draw_c, draw_load, draw_en,
        input  draw_done
    );

    modport slave (
        input  draw_x, draw_y, draw_w, draw_h, draw_c, draw_load, draw_en,
        output draw_done
    );
endinterface

// File: rtl/render_scheduler.sv
// Frame sequencer: walks the object table on frame_tick and feeds drawable slots to the draw engine.
// Optional erase pass of each slot's previous rectangle is enabled by defining ERASE_PASS_EN.
module render_scheduler #(
    parameter int         NUM_OBJ   = 8,
    parameter int         IDX_W     = 3,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    output logic [IDX_W-1:0]     obj_idx,
    input  logic                 obj_valid,
    input  logic [7:0]           obj_x,
    input  logic [6:0]           obj_y,
    input  logic [4:0]           obj_w,
    input  logic [4:0]           obj_h,
    input  logic [2:0]           obj_c,
    render_scheduler_if.master   draw,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overrun
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SCAN    = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_DRAW    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
    localparam logic [2:0] S_FINISH  = 3'd5;
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_OBJ - 1);

    logic [2:0]       state_r, state_s;
    logic [IDX_W-1:0] slot_r, slot_s;
    logic             drawable_s, latch_obj_s, latch_erase_s, erase_req_s, erase_phase_s;
    logic [7:0]       erase_x_s;
    logic [6:0]       erase_y_s;
    logic [4:0]       erase_w_s, erase_h_s;
    logic [7:0]       x_r;
    logic [6:0]       y_r;
    logic [4:0]       w_r, h_r;
    logic [2:0]       c_r;
    logic             load_r, en_r, busy_r, done_r, overrun_r;

    assign drawable_s = obj_valid && (obj_w != 5'd0) && (obj_h != 5'd0);

`ifdef ERASE_PASS_EN
    logic [7:0]         prev_x_r [NUM_OBJ];
    logic [6:0]         prev_y_r [NUM_OBJ];
    logic [4:0]         prev_w_r [NUM_OBJ];
    logic [4:0]         prev_h_r [NUM_OBJ];
    logic [NUM_OBJ-1:0] prev_drawn_r;
    logic               erased_r, erase_phase_r;

    // erased_r marks that the current slot's erase already ran, so the revisit goes to the draw phase
    assign erase_req_s   = prev_drawn_r[slot_r] && !erased_r;
    assign erase_phase_s = erase_phase_r;
    assign erase_x_s     = prev_x_r[slot_r];
    assign erase_y_s     = prev_y_r[slot_r];
    assign erase_w_s     = prev_w_r[slot_r];
    assign erase_h_s     = prev_h_r[slot_r];

    // Previous-geometry table and erase-phase tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_drawn_r  <= {NUM_OBJ{1'b0}};
            erased_r      <= 1'b0;
            erase_phase_r <= 1'b0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                prev_x_r[i] <= 8'd0;
                prev_y_r[i] <= 7'd0;
                prev_w_r[i] <= 5'd0;
                prev_h_r[i] <= 5'd0;
            end
        end else begin
            if (latch_erase_s) begin
                erase_phase_r <= 1'b1;
            end else if (state_r == S_RELEASE) begin
                erase_phase_r <= 1'b0;
            end else begin
                erase_phase_r <= erase_phase_r;
            end
            if ((state_r == S_RELEASE) && erase_phase_r) begin
                erased_r <= 1'b1;
            end else if ((state_r == S_SCAN) && !erase_req_s) begin
                erased_r <= 1'b0;
            end else begin
                erased_r <= erased_r;
            end
            if ((state_r == S_SCAN) && !erase_req_s) begin
                if (drawable_s) begin
                    prev_x_r[slot_r]     <= obj_x;
                    prev_y_r[slot_r]     <= obj_y;
                    prev_w_r[slot_r]     <= obj_w;
                    prev_h_r[slot_r]     <= obj_h;
                    prev_drawn_r[slot_r] <= 1'b1;
                end else begin
                    prev_drawn_r[slot_r] <= 1'b0;
                end
            end
        end
    end
`else
    assign erase_req_s   = 1'b0;
    assign erase_phase_s = 1'b0;
    assign erase_x_s     = 8'd0;
    assign erase_y_s     = 7'd0;
    assign erase_w_s     = 5'd0;
    assign erase_h_s     = 5'd0;
`endif

    // Next-state and slot sequencing
    always_comb begin
        state_s       = state_r;
        slot_s        = slot_r;
        latch_obj_s   = 1'b0;
        latch_erase_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (frame_tick) begin
                    slot_s  = {IDX_W{1'b0}};
                    state_s = S_SCAN;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_SCAN: begin
                if (erase_req_s) begin
                    latch_erase_s = 1'b1;
                    state_s       = S_LOAD;
                end else if (drawable_s) begin
                    latch_obj_s = 1'b1;
                    state_s     = S_LOAD;
                end else if (slot_r == LAST_SLOT) begin
                    state_s = S_FINISH;
                end else begin
                    slot_s = slot_r + IDX_W'(1);
                end
            end
            S_LOAD: begin
                state_s = S_DRAW;
            end
            S_DRAW: begin
                if (draw.draw_done) begin
                    state_s = S_RELEASE;
                end else begin
                    state_s = S_DRAW;
                end
            end
            S_RELEASE: begin
                if (erase_phase_s) begin
                    state_s = S_SCAN;
                end else if (slot_r == LAST_SLOT) begin
                    state_s = S_FINISH;
                end else begin
                    slot_s  = slot_r + IDX_W'(1);
                    state_s = S_SCAN;
                end
            end
            S_FINISH: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
                slot_s  = {IDX_W{1'b0}};
            end
        endcase
    end

    // State, registered handshake outputs and descriptor latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_IDLE;
            slot_r    <= {IDX_W{1'b0}};
            load_r    <= 1'b0;
            en_r      <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
            x_r       <= 8'd0;
            y_r       <= 7'd0;
            w_r       <= 5'd0;
            h_r       <= 5'd0;
            c_r       <= 3'd0;
        end else begin
            state_r   <= state_s;
            slot_r    <= slot_s;
            load_r    <= (state_s == S_LOAD);
            en_r      <= (state_s == S_DRAW);
            busy_r    <= (state_s != S_IDLE);
            done_r    <= (state_s == S_FINISH);
            overrun_r <= overrun_r || (frame_tick && (state_r != S_IDLE));
            if (latch_obj_s) begin
                x_r <= obj_x;
                y_r <= obj_y;
                w_r <= obj_w;
                h_r <= obj_h;
                c_r <= obj_c;
            end else if (latch_erase_s) begin
                x_r <= erase_x_s;
                y_r <= erase_y_s;
                w_r <= erase_w_s;
                h_r <= erase_h_s;
                c_r <= BG_COLOUR;
            end else begin
                x_r <= x_r;
                y_r <= y_r;
                w_r <= w_r;
                h_r <= h_r;
                c_r <= c_r;
            end
        end
    end

    assign obj_idx        = slot_r;
    assign draw.draw_x    = x_r;
    assign draw.draw_y    = y_r;
    assign draw.draw_w    = w_r;
    assign draw.draw_h    = h_r;
    assign draw.draw_c    = c_r;
    assign draw.draw_load = load_r;
    assign draw.draw_en   = en_r;
    assign busy           = busy_r;
    assign frame_done     = done_r;
    assign overrun        = overrun_r;
endmodule
